// File: rtl/tcp_unconf_mem_requester.sv
// Per-connection unconfirmed-memory requester: tracks unacked segment descriptors,
// retires them on cumulative ACKs and requests the arbiter for retransmission on timeout.
module tcp_unconf_mem_requester #(
    parameter int unsigned DESC_DEPTH = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned SEQ_W      = 32,
    parameter int unsigned RTO_CYC    = 4096,
    parameter int unsigned MAX_RETRY  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [LEN_W-1:0]  push_len_i,
    input  logic [SEQ_W-1:0]  push_seq_end_i,
    input  logic              ack_vld_i,
    input  logic [SEQ_W-1:0]  ack_num_i,
    output logic              irq_o,
    input  logic              sel_i,
    input  logic              sel_rdy_i,
    input  logic              wr_allow_i,
    output logic              rtx_vld_o,
    output logic [ADDR_W-1:0] rtx_addr_o,
    output logic [LEN_W-1:0]  rtx_len_o,
    output logic              stop_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              ovf_o,
    output logic              err_o
);

    localparam int unsigned PTR_W = $clog2(DESC_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(RTO_CYC);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SEQ_W-1:0]  seq_end;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    desc_t             mem [DESC_DEPTH];
    desc_t             head_desc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [SEQ_W-1:0]  ack_reg;
    logic [SEQ_W-1:0]  ack_diff;
    logic [TMR_W-1:0]  timer;
    logic [RTY_W-1:0]  retry;
    state_t            state;
    state_t            state_next;
    logic              not_empty;
    logic              full_c;
    logic              push_ok;
    logic              pop;
    logic              expire;
    logic              grant;
    logic              accept;

    // FIFO bookkeeping, modular ACK compare and timer expiry
    always_comb begin
        head_desc  = mem[head];
        not_empty  = (count != '0);
        full_c     = (count == CNT_W'(DESC_DEPTH));
        push_ok    = push_i && !full_c;
        ack_diff   = ack_reg - head_desc.seq_end;
        pop        = not_empty && ($signed(ack_diff) >= 0);
        count_next = count + CNT_W'(push_ok) - CNT_W'(pop);
        expire     = not_empty && !pop && (timer == TMR_W'(RTO_CYC - 1));
        grant      = sel_i && sel_rdy_i;
        accept     = rtx_vld_o && wr_allow_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (expire) state_next = REQ;
            REQ: begin
                // an ACK that drains the FIFO cancels the request without a stop pulse
                if (count_next == '0) begin
                    state_next = IDLE;
                end else if (grant) begin
                    state_next = LATCH;
                end
            end
            LATCH:   state_next = SEND;
            SEND:    if (accept) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= desc_t'{addr: push_addr_i, len: push_len_i, seq_end: push_seq_end_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            empty_o    <= 1'b1;
            full_o     <= 1'b0;
            ovf_o      <= 1'b0;
            ack_reg    <= '0;
            timer      <= '0;
            retry      <= '0;
            err_o      <= 1'b0;
            rtx_addr_o <= '0;
            rtx_len_o  <= '0;
            irq_o      <= 1'b0;
            rtx_vld_o  <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            if (push_ok)          tail  <= tail + PTR_W'(1);
            if (push_i && full_c) ovf_o <= 1'b1;
            if (pop)              head  <= head + PTR_W'(1);
            count   <= count_next;
            empty_o <= (count_next == '0);
            full_o  <= (count_next == CNT_W'(DESC_DEPTH));
            if (ack_vld_i) ack_reg <= ack_num_i;

            if (state != IDLE || !not_empty || pop || expire) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end

            // retry count tracks retransmissions of the current head only
            if (pop) begin
                retry <= '0;
            end else if (state == SEND && accept) begin
                if (retry < RTY_W'(MAX_RETRY + 1)) retry <= retry + RTY_W'(1);
                if (retry >= RTY_W'(MAX_RETRY))    err_o <= 1'b1;
            end

            if (state == LATCH) begin
                rtx_addr_o <= head_desc.addr;
                rtx_len_o  <= head_desc.len;
            end

            irq_o     <= (state_next == REQ) || (state_next == LATCH) || (state_next == SEND);
            rtx_vld_o <= (state_next == SEND);
            stop_o    <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_tcp_unconf_mem_requester.sv
// Directed self-checking bench for tcp_unconf_mem_requester (short RTO for run time).
module tb_tcp_unconf_mem_requester;

    localparam int unsigned RTO = 32;
    localparam int unsigned MAXR = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_i = 1'b0;
    logic [15:0] push_addr_i = '0;
    logic [10:0] push_len_i = '0;
    logic [31:0] push_seq_end_i = '0;
    logic        ack_vld_i = 1'b0;
    logic [31:0] ack_num_i = '0;
    logic        irq_o;
    logic        sel_i = 1'b0;
    logic        sel_rdy_i = 1'b0;
    logic        wr_allow_i = 1'b0;
    logic        rtx_vld_o;
    logic [15:0] rtx_addr_o;
    logic [10:0] rtx_len_o;
    logic        stop_o;
    logic        empty_o;
    logic        full_o;
    logic        ovf_o;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    tcp_unconf_mem_requester #(
        .DESC_DEPTH(8), .ADDR_W(16), .LEN_W(11), .SEQ_W(32), .RTO_CYC(RTO), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst(rst),
        .push_i(push_i), .push_addr_i(push_addr_i), .push_len_i(push_len_i),
        .push_seq_end_i(push_seq_end_i),
        .ack_vld_i(ack_vld_i), .ack_num_i(ack_num_i),
        .irq_o(irq_o), .sel_i(sel_i), .sel_rdy_i(sel_rdy_i), .wr_allow_i(wr_allow_i),
        .rtx_vld_o(rtx_vld_o), .rtx_addr_o(rtx_addr_o), .rtx_len_o(rtx_len_o),
        .stop_o(stop_o), .empty_o(empty_o), .full_o(full_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // stimulus helpers: all driving happens at negedge, one posedge per call step
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_desc(input logic [15:0] a, input logic [10:0] l, input logic [31:0] s);
        push_i = 1'b1; push_addr_i = a; push_len_i = l; push_seq_end_i = s;
        @(negedge clk);
        push_i = 1'b0;
    endtask

    task automatic send_ack(input logic [31:0] n);
        ack_vld_i = 1'b1; ack_num_i = n;
        @(negedge clk);
        ack_vld_i = 1'b0;
    endtask

    task automatic wait_irq();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (irq_o === 1'b1) ok = 1'b1;
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL wait_irq: irq_o never rose within 200 cycles"); end
    endtask

    task automatic do_grant();
        sel_i = 1'b1; sel_rdy_i = 1'b1;
        @(negedge clk);
        sel_i = 1'b0; sel_rdy_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({irq_o, rtx_vld_o, rtx_addr_o, rtx_len_o, stop_o, empty_o, full_o, ovf_o, err_o} !== {1'b0, 1'b0, 16'h0, 11'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: irq=%b vld=%b addr=%h len=%h stop=%b empty=%b full=%b ovf=%b err=%b, required 0 0 0 0 0 1 0 0 0",
                     irq_o, rtx_vld_o, rtx_addr_o, rtx_len_o, stop_o, empty_o, full_o, ovf_o, err_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_rto_retransmit();
        do_reset();
        push_desc(16'h1000, 11'd100, 32'd100);
        push_desc(16'h2000, 11'd200, 32'd200);
        push_desc(16'h3000, 11'd300, 32'd300);
        repeat (29) @(negedge clk);
        n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL rto_early: irq=%b required 0", irq_o); end
        @(negedge clk);
        n_vec++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL rto_exact: irq=%b required 1", irq_o); end
        wr_allow_i = 1'b1;
        do_grant();
        n_vec++;
        if ({rtx_vld_o, irq_o, rtx_addr_o, rtx_len_o} !== {1'b1, 1'b1, 16'h1000, 11'd100}) begin
            n_err++; $display("FAIL rtx_desc0: vld=%b irq=%b addr=%h len=%0d required 1 1 1000 100", rtx_vld_o, irq_o, rtx_addr_o, rtx_len_o);
        end
        @(negedge clk);
        wr_allow_i = 1'b0;
        n_vec++;
        if ({stop_o, irq_o, rtx_vld_o} !== 3'b100) begin
            n_err++; $display("FAIL stop_cycle: stop=%b irq=%b vld=%b required 1 0 0", stop_o, irq_o, rtx_vld_o);
        end
        @(negedge clk);
        n_vec++;
        if ({stop_o, irq_o} !== 2'b00) begin n_err++; $display("FAIL stop_single: stop=%b irq=%b required 0 0", stop_o, irq_o); end
    endtask

    task automatic test_ack_retire();
        do_reset();
        push_desc(16'h1000, 11'd100, 32'd100);
        push_desc(16'h2000, 11'd200, 32'd200);
        push_desc(16'h3000, 11'd300, 32'd300);
        send_ack(32'd250);
        repeat (2) @(negedge clk);
        n_vec++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL ack250_partial: empty=%b required 0", empty_o); end
        repeat (31) @(negedge clk);
        n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL timer_restart_early: irq=%b required 0", irq_o); end
        @(negedge clk);
        n_vec++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL timer_restart_exact: irq=%b required 1", irq_o); end
        send_ack(32'd300);
        n_vec++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL req_hold: irq=%b required 1", irq_o); end
        @(negedge clk);
        n_vec++;
        if ({irq_o, empty_o, stop_o} !== 3'b010) begin
            n_err++; $display("FAIL req_cancel: irq=%b empty=%b stop=%b required 0 1 0", irq_o, empty_o, stop_o);
        end
        begin
            bit seen = 1'b0;
            repeat (40) begin @(negedge clk); if (irq_o !== 1'b0 || stop_o !== 1'b0) seen = 1'b1; end
            n_vec++; if (seen) begin n_err++; $display("FAIL req_cancel_quiet: irq/stop activity seen=1 required 0"); end
        end
    endtask

    task automatic test_ack_idle();
        bit seen = 1'b0;
        do_reset();
        push_desc(16'h0400, 11'd40, 32'd50);
        send_ack(32'd60);
        n_vec++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL ack_idle_pre: empty=%b required 0", empty_o); end
        @(negedge clk);
        n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL ack_idle_empty: empty=%b required 1", empty_o); end
        repeat (40) begin @(negedge clk); if (irq_o !== 1'b0) seen = 1'b1; end
        n_vec++; if (seen) begin n_err++; $display("FAIL ack_idle_noirq: irq seen=1 required 0"); end
    endtask

    task automatic test_wr_stall();
        bit bad = 1'b0;
        do_reset();
        push_desc(16'hABCD, 11'h7FF, 32'd1000);
        wait_irq();
        do_grant();
        push_i = 1'b1; push_addr_i = 16'h2222; push_len_i = 11'd22; push_seq_end_i = 32'd2000;
        ack_vld_i = 1'b1; ack_num_i = 32'd1000;
        for (int i = 0; i < 20; i++) begin
            if (rtx_vld_o !== 1'b1 || rtx_addr_o !== 16'hABCD || rtx_len_o !== 11'h7FF || stop_o !== 1'b0) bad = 1'b1;
            @(negedge clk);
            push_i = 1'b0; ack_vld_i = 1'b0;
        end
        n_vec++;
        if (bad || rtx_vld_o !== 1'b1 || rtx_addr_o !== 16'hABCD || rtx_len_o !== 11'h7FF) begin
            n_err++; $display("FAIL stall_hold: vld=%b addr=%h len=%h unstable=%b required 1 abcd 7ff 0", rtx_vld_o, rtx_addr_o, rtx_len_o, bad);
        end
        wr_allow_i = 1'b1;
        @(negedge clk);
        wr_allow_i = 1'b0;
        n_vec++;
        if ({stop_o, rtx_vld_o, irq_o} !== 3'b100) begin
            n_err++; $display("FAIL stall_accept: stop=%b vld=%b irq=%b required 1 0 0", stop_o, rtx_vld_o, irq_o);
        end
        @(negedge clk);
        n_vec++; if (stop_o !== 1'b0) begin n_err++; $display("FAIL stall_stop_once: stop=%b required 0", stop_o); end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        push_desc(16'h0010, 11'd16, 32'h0000_0010);
        send_ack(32'hFFFF_FFF0);
        repeat (2) @(negedge clk);
        n_vec++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL wrap_nopop: empty=%b required 0", empty_o); end
        send_ack(32'h0000_0010);
        @(negedge clk);
        n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL wrap_pop: empty=%b required 1", empty_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_desc(16'h0100 + 16'(i), 11'd10, 32'(10 * (i + 1)));
            if (i == 7) begin
                n_vec++;
                if ({full_o, ovf_o} !== 2'b10) begin n_err++; $display("FAIL full_at_8: full=%b ovf=%b required 1 0", full_o, ovf_o); end
            end
        end
        n_vec++;
        if ({full_o, ovf_o} !== 2'b11) begin n_err++; $display("FAIL ovf_at_9: full=%b ovf=%b required 1 1", full_o, ovf_o); end
        send_ack(32'd80);
        @(negedge clk);
        n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL full_clear: full=%b required 0", full_o); end
        repeat (6) @(negedge clk);
        n_vec++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL drain_7: empty=%b required 0", empty_o); end
        @(negedge clk);
        n_vec++;
        if ({empty_o, ovf_o} !== 2'b11) begin n_err++; $display("FAIL drain_8: empty=%b ovf=%b required 1 1", empty_o, ovf_o); end
    endtask

    task automatic test_grant_ignored();
        do_reset();
        push_desc(16'h0500, 11'd5, 32'd500);
        sel_i = 1'b1; sel_rdy_i = 1'b1;
        repeat (5) @(negedge clk);
        sel_i = 1'b0; sel_rdy_i = 1'b0;
        n_vec++;
        if ({irq_o, rtx_vld_o, stop_o} !== 3'b000) begin
            n_err++; $display("FAIL grant_idle: irq=%b vld=%b stop=%b required 0 0 0", irq_o, rtx_vld_o, stop_o);
        end
    endtask

    task automatic test_retry_limit();
        do_reset();
        push_desc(16'h0600, 11'd6, 32'd600);
        for (int i = 0; i < int'(MAXR) + 1; i++) begin
            wait_irq();
            wr_allow_i = 1'b1;
            do_grant();
            @(negedge clk);
            wr_allow_i = 1'b0;
            n_vec++;
            if ({stop_o, err_o} !== {1'b1, (i + 1 > int'(MAXR))}) begin
                n_err++; $display("FAIL retry_%0d: stop=%b err=%b required 1 %b", i, stop_o, err_o, (i + 1 > int'(MAXR)));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_send();
        wait_irq();
        do_grant();
        n_vec++;
        if ({rtx_vld_o, err_o} !== 2'b11) begin n_err++; $display("FAIL pre_reset_send: vld=%b err=%b required 1 1", rtx_vld_o, err_o); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({irq_o, rtx_vld_o, rtx_addr_o, rtx_len_o, stop_o, empty_o, full_o, ovf_o, err_o} !== {1'b0, 1'b0, 16'h0, 11'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_send: irq=%b vld=%b addr=%h len=%h stop=%b empty=%b full=%b ovf=%b err=%b, required 0 0 0 0 0 1 0 0 0",
                     irq_o, rtx_vld_o, rtx_addr_o, rtx_len_o, stop_o, empty_o, full_o, ovf_o, err_o);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rto_retransmit();
        test_ack_retire();
        test_ack_idle();
        test_wr_stall();
        test_seq_wrap();
        test_overflow();
        test_grant_ignored();
        test_retry_limit();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tcp_unconf_mem_requester.md
Name: tcp_unconf_mem_requester

Overview:
- Per-connection client of the unconfirmed-memory arbiter.
- Keeps a FIFO of transmitted-but-unacknowledged segment descriptors (buffer pointer, length, end sequence number) and retires them on incoming ACKs.
- Runs a retransmit timer on the oldest entry. On expiry it raises an interrupt toward the arbiter, waits for its grant, then hands the oldest descriptor to the end controller and signals stop so the arbiter can rotate.

Parameters:
- DESC_DEPTH, 8: descriptor FIFO entries (power of 2).
- ADDR_W, 16: unconfirmed-memory pointer width.
- LEN_W, 11: segment length width (bytes).
- SEQ_W, 32: TCP sequence number width.
- RTO_CYC, 4096: retransmit timeout in clk cycles (≥2).
- MAX_RETRY, 7: retransmissions of one head entry before err_o.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- push_i  in  1  store descriptor (segment just sent).
- push_addr_i  in  ADDR_W  segment start pointer.
- push_len_i  in  LEN_W  segment length.
- push_seq_end_i  in  SEQ_W  sequence number after the last byte.
- ack_vld_i  in  1  ACK number valid, single-cycle.
- ack_num_i  in  SEQ_W  received cumulative ACK.
- irq_o  out  1  request to arbiter.
- sel_i  in  1  this device's arbiter select bit.
- sel_rdy_i  in  1  arbiter grant-ready flag.
- wr_allow_i  in  1  end controller accepts descriptor.
- rtx_vld_o  out  1  retransmit descriptor valid.
- rtx_addr_o  out  ADDR_W  retransmit pointer.
- rtx_len_o  out  LEN_W  retransmit length.
- stop_o  out  1  one-cycle release pulse to arbiter.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- ovf_o  out  1  sticky: push while full.
- err_o  out  1  sticky: retry limit exceeded.

Behaviour:
- Reset: FIFO empty, timer 0, FSM IDLE, retry count 0. Outputs: irq_o=0, rtx_vld_o=0, rtx_addr_o=0, rtx_len_o=0, stop_o=0, empty_o=1, full_o=0, ovf_o=0, err_o=0. Reset mid-transfer abandons the transfer; the arbiter recovers on its own reset.
- FIFO:
  - Push when not full writes at tail. Push when full is dropped and sets ovf_o.
  - Push and pop in the same cycle are both performed; count unchanged.
  - empty_o and full_o are registered from count.
- ACK retire:
  - ack_vld_i latches ack_num into ack_reg; ack_reg persists until the next ack_vld_i.
  - Each cycle, if the FIFO is not empty and the signed difference (ack_reg − head.seq_end), computed modulo 2^SEQ_W, is ≥0, the head is popped.
  - At most one pop per cycle, so N covered entries need N cycles. Sequence wrap is handled by the modular compare.
  - A pop clears the retry count and restarts the timer.
- Timer:
  - Counts only while not empty and FSM=IDLE.
  - Reset to 0 on pop, on push into an empty FIFO, and on return to IDLE.
  - Reaching RTO_CYC−1 moves the FSM to REQ.
- FSM states:
  - IDLE: irq_o=0. Timer expiry with FIFO not empty → REQ.
  - REQ: irq_o=1. If the FIFO becomes empty through ACK → IDLE (irq_o drops next cycle, no stop_o). If sel_i & sel_rdy_i → LATCH.
  - LATCH: copy head addr/len into rtx regs; irq_o stays 1 → SEND. Later ACK pops do not alter the latched copy.
  - SEND: rtx_vld_o=1; hold addr/len stable until the cycle rtx_vld_o & wr_allow_i, then → DONE. No timeout while waiting for wr_allow_i.
  - DONE: stop_o=1 for exactly one cycle; irq_o=0 from this cycle; rtx_vld_o=0. Increment the saturating retry count; if it exceeds MAX_RETRY, set err_o. → IDLE.
- irq_o must be deasserted in the stop_o cycle so the arbiter does not re-grant on the following cycle.
- Grant (sel_i & sel_rdy_i) seen outside REQ is ignored.

Test Plan:
- Push 3 descriptors (seq_end 100/200/300), no ACK → irq_o rises exactly RTO_CYC cycles after the first push. Grant → rtx_addr/len equal descriptor 0; with wr_allow_i=1, rtx_vld_o is high 1 cycle, stop_o pulses once, irq_o=0 in the stop cycle.
- Same setup, ack_num=250 → entries 0 and 1 popped over 2 cycles, count=1, timer restarted; ack_num=300 → empty_o=1, no irq.
- ACK covering all entries while in REQ → irq_o deasserts, no stop_o, FSM returns to IDLE.
- wr_allow_i held low 20 cycles in SEND → rtx_vld_o and addr/len stable throughout; stop_o one cycle after acceptance.
- Sequence wrap: seq_end=0x0000_0010, ack_num=0xFFFF_FFF0 → no pop; ack_num=0x0000_0010 → pop. Push 9 entries with DESC_DEPTH=8 → full_o=1, ovf_o=1, 9th entry dropped.
- MAX_RETRY+1 timeouts with no ACK → err_o set on the final DONE. Assert rst mid-SEND → all outputs at reset values next cycle.
